// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the data-memory access path.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_POISON     = 32'hDEADBEEF;
    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return (byte_off & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_wdog.sv
// Saturating BUSY-cycle counter for the data-memory timeout; o_expired marks
// the cycle in which the count reaches LIMIT.
module dmem_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt counts completed enabled cycles, so the current one is the LIMIT-th
    assign o_expired = i_en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: EX/MEM load/store -> req/ack, with pipeline stall.
// Optional BUSY watchdog abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_memRead_ex_mem,
    input  logic              ctrl_memWrite_ex_mem,
    input  logic [ADDR_W-1:0] addr_ex_mem,
    input  logic [DATA_W-1:0] wdata_ex_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_pipe,
    output logic              bubble_mem_wb,
    output logic [DATA_W-1:0] read_data_from_mem,
    output logic              err_misaligned,
    output logic              err_timeout
);

    dmem_state_t       r_state, w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_read_data, w_read_data_nxt;
    logic              r_err_mis, w_err_mis_nxt;
    logic              w_access;
    logic              w_aligned;
    logic              w_both;

    assign w_access  = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    assign w_both    = ctrl_memRead_ex_mem & ctrl_memWrite_ex_mem;
    assign w_aligned = is_word_aligned(addr_ex_mem[1:0]);

`ifdef DMEM_TIMEOUT_EN
    logic r_err_timeout, w_err_timeout_nxt;
    logic w_wdog_clear, w_wdog_en, w_wdog_expired;

    assign w_wdog_en = (r_state == BUSY);

    dmem_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_wdog_clear),
        .i_en      (w_wdog_en),
        .o_expired (w_wdog_expired)
    );
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_read_data_nxt = r_read_data;
        w_err_mis_nxt   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        w_err_timeout_nxt = r_err_timeout;
        w_wdog_clear      = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_mem_addr_nxt  = addr_ex_mem;
                        w_mem_wdata_nxt = wdata_ex_mem;
                        // simultaneous read+write is issued as a read
                        w_mem_we_nxt    = ctrl_memWrite_ex_mem & ~ctrl_memRead_ex_mem;
                        w_mem_req_nxt   = 1'b1;
                        w_state_nxt     = BUSY;
`ifdef DMEM_TIMEOUT_EN
                        w_wdog_clear    = 1'b1;
`endif
                    end else begin
                        w_err_mis_nxt   = ~w_both;
                        w_read_data_nxt = '0;
                        w_state_nxt     = DONE;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (!r_mem_we) begin
                        w_read_data_nxt = mem_rdata;
                    end
                    w_state_nxt = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (w_wdog_expired) begin
                    w_mem_req_nxt     = 1'b0;
                    w_err_timeout_nxt = 1'b1;
                    w_read_data_nxt   = DATA_W'(DMEM_POISON);
                    w_state_nxt       = DONE;
                end
`endif
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_read_data <= '0;
            r_err_mis   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_read_data <= w_read_data_nxt;
            r_err_mis   <= w_err_mis_nxt;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    assign mem_req            = r_mem_req;
    assign mem_we             = r_mem_we;
    assign mem_addr           = r_mem_addr;
    assign mem_wdata          = r_mem_wdata;
    assign read_data_from_mem = r_read_data;
    assign err_misaligned     = r_err_mis;
    assign stall_pipe         = ((r_state == IDLE) && w_access) || (r_state == BUSY);
    assign bubble_mem_wb      = stall_pipe;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl; timeout vectors run when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_pipe, bubble_mem_wb, err_misaligned, err_timeout;
    logic [31:0] read_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ctrl_memRead_ex_mem  (rd),
        .ctrl_memWrite_ex_mem (wr),
        .addr_ex_mem          (addr),
        .wdata_ex_mem         (wdata),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_ack              (mem_ack),
        .mem_rdata            (mem_rdata),
        .stall_pipe           (stall_pipe),
        .bubble_mem_wb        (bubble_mem_wb),
        .read_data_from_mem   (read_data),
        .err_misaligned       (err_misaligned),
        .err_timeout          (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with the controller in IDLE; returns
    // one falling edge after the DONE cycle (controller back in IDLE).
    task automatic do_access(
        input  logic        a_rd,
        input  logic        a_wr,
        input  logic [31:0] a_addr,
        input  logic [31:0] a_wdata,
        input  int          waits,
        input  logic [31:0] a_rdata,
        output int          stall_n,
        output int          req_n,
        output int          mis_n,
        output int          bad_n,
        output int          first_req_cyc,
        output int          done_cyc,
        output logic [31:0] rd_done
    );
        int   busy;
        logic done;
        logic exp_we;
        stall_n = 0; req_n = 0; mis_n = 0; bad_n = 0;
        first_req_cyc = -1; done_cyc = -1; rd_done = '0;
        busy = 0; done = 1'b0;
        exp_we = a_wr & ~a_rd;
        rd = a_rd; wr = a_wr; addr = a_addr; wdata = a_wdata;
        mem_rdata = a_rdata;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (err_misaligned) mis_n++;
            if (stall_pipe) stall_n++;
            if (bubble_mem_wb !== stall_pipe) bad_n++;
            if (mem_req) begin
                req_n++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (mem_addr !== a_addr || mem_wdata !== a_wdata || mem_we !== exp_we) bad_n++;
                busy++;
                mem_ack = (busy == waits + 1);
            end else begin
                mem_ack = 1'b0;
            end
            if (!stall_pipe && i > 0) begin
                done = 1'b1;
                done_cyc = cyc;
                rd_done = read_data;
                rd = 1'b0; wr = 1'b0;
            end
            @(negedge clk);
        end
        if (!done) chk("access_bound", 32'd0, 32'd1);
        mem_ack = 1'b0;
        #1;
        if (err_misaligned) mis_n++;
        if (mem_req) bad_n++;
    endtask

    int          s_n, q_n, m_n, b_n, fr, dc, fr2, dc2;
    logic [31:0] rdd;

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_pipe}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_err", {30'd0, err_misaligned, err_timeout}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;

        // 1: aligned load, ack in first BUSY cycle
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h12345678, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("ld_stall", s_n, 2);
        chk("ld_req", q_n, 1);
        chk("ld_rdata", rdd, 32'h12345678);
        chk("ld_stable", b_n, 0);
        chk("ld_mis", m_n, 0);

        // 2: store, five wait cycles
        do_access(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 5, 32'hFFFF0000, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("st_req", q_n, 6);
        chk("st_stall", s_n, 7);
        chk("st_stable", b_n, 0);
        chk("st_rdata_kept", rdd, 32'h12345678);

        // 3: misaligned load
        do_access(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h77777777, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("mis_req", q_n, 0);
        chk("mis_pulse", m_n, 1);
        chk("mis_stall", s_n, 1);
        chk("mis_rdata", rdd, 32'h0);

        // read+write together behaves as a read
        do_access(1'b1, 1'b1, 32'h20, 32'h11111111, 0, 32'h0BADF00D, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("rw_rdata", rdd, 32'h0BADF00D);
        chk("rw_stable", b_n, 0);
        chk("rw_mis", m_n, 0);

        // 4: back-to-back loads
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hA5A50010, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("b2b1_rdata", rdd, 32'hA5A50010);
        chk("b2b1_req", q_n, 2);
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 0, 32'h5A5A0014, s_n, q_n, m_n, b_n, fr2, dc2, rdd);
        chk("b2b2_rdata", rdd, 32'h5A5A0014);
        chk("b2b2_req", q_n, 1);
        chk("b2b_gap", fr2 - dc, 2);

        // 5: asynchronous reset mid-transaction, then a stray ack
        rd = 1'b1; addr = 32'h300; mem_rdata = 32'h0;
        @(negedge clk); #1;
        chk("ar_busy_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0; rd = 1'b0;
        #1;
        chk("ar_req", {31'd0, mem_req}, 32'd0);
        chk("ar_stall", {31'd0, stall_pipe}, 32'd0);
        chk("ar_bubble", {31'd0, bubble_mem_wb}, 32'd0);
        chk("ar_rdata", read_data, 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_ack = 1'b0; #1;
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, stall_pipe}, 32'd0);
        chk("late_ack_rdata", read_data, 32'd0);
        @(negedge clk); #1;

`ifdef DMEM_TIMEOUT_EN
        // ack in the eighth BUSY cycle beats the timeout
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 7, 32'h13579BDF, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("to_race_rdata", rdd, 32'h13579BDF);
        chk("to_race_req", q_n, 8);
        chk("to_race_flag", {31'd0, err_timeout}, 32'd0);

        // 6: ack withheld
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 1000, 32'h0, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("to_req", q_n, 8);
        chk("to_stall", s_n, 9);
        chk("to_rdata", rdd, 32'hDEADBEEF);
        chk("to_flag", {31'd0, err_timeout}, 32'd1);
        do_access(1'b0, 1'b1, 32'h48, 32'h1, 0, 32'h0, s_n, q_n, m_n, b_n, fr, dc, rdd);
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);
`else
        chk("to_tied", {31'd0, err_timeout}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
